// File: rtl/fabric_check_pkg.sv
// Shared types and helpers for the fabric random checker.
package fabric_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_DONE
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, Galois form, shifting right
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // An all-zero seed would lock the LFSR at zero forever
  function automatic logic [31:0] fix_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? 32'd1 : seed;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage

// File: rtl/prng_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance enable.
module prng_lfsr32
  import fabric_check_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  localparam logic [31:0] RESET_STATE = fix_seed(RESET_SEED);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Next state: load wins over advance, otherwise hold
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    if (load) begin
      state_d = fix_seed(seed);
    end else if (advance) begin
      state_d = lfsr_next(state_q);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop update from pre-edge values.
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fabric_random_checker.sv
// Random-stimulus self-test checker: drives stim, compares DUT vs REF with
// a don't-care mask, skips a warm-up window and records the first failure.
module fabric_random_checker
  import fabric_check_pkg::*;
#(
  parameter int          IN_W       = 2,
  parameter int          OUT_W      = 1,
  parameter int          WARMUP     = 1,
  parameter int          NUM_CYCLES = 400,
  parameter int          ERR_W      = 16,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  localparam int         CNT_W      = $clog2(WARMUP + NUM_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] ref_out,
  input  logic [OUT_W-1:0] ref_dc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [OUT_W-1:0] first_err_mask
);

  // Cycle indices at which the warm-up and the whole run end
  localparam logic [CNT_W-1:0] WARM_LAST_IDX = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] RUN_LAST_IDX  = CNT_W'(WARMUP + NUM_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] first_err_cycle_q, first_err_cycle_d;
  logic [OUT_W-1:0] first_err_mask_q, first_err_mask_d;

  logic             accept;
  logic             busy_w;
  logic [OUT_W-1:0] mismatch;
  logic [31:0]      lfsr_state;

  assign busy_w   = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch = (dut_out ^ ref_out) & ~ref_dc;

  prng_lfsr32 #(
    .RESET_SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .advance(busy_w),
    .seed   (SEED),
    .state  (lfsr_state)
  );

  // Next-state logic: run phases are sequenced by the shared cycle index
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      ST_WARMUP:        if (cyc_q == WARM_LAST_IDX) state_d = ST_RUN;
      ST_RUN:           if (cyc_q == RUN_LAST_IDX) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Cycle index, mismatch counting and first-failure capture
  always_comb begin
    cyc_d             = cyc_q;
    err_count_d       = err_count_q;
    err_pulse_d       = 1'b0;
    first_err_cycle_d = first_err_cycle_q;
    first_err_mask_d  = first_err_mask_q;
    if (accept) begin
      cyc_d             = '0;
      err_count_d       = '0;
      first_err_cycle_d = '0;
      first_err_mask_d  = '0;
    end else if (busy_w) begin
      cyc_d = cyc_q + CNT_W'(1);
      if ((state_q == ST_RUN) && (|mismatch)) begin
        err_pulse_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        // Count never wraps, so zero means no mismatch seen yet this run
        if (err_count_q == '0) begin
          first_err_cycle_d = cyc_q;
          first_err_mask_d  = mismatch;
        end
      end
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      cyc_q             <= '0;
      err_count_q       <= '0;
      err_pulse_q       <= 1'b0;
      first_err_cycle_q <= '0;
      first_err_mask_q  <= '0;
    end else begin
      state_q           <= state_d;
      cyc_q             <= cyc_d;
      err_count_q       <= err_count_d;
      err_pulse_q       <= err_pulse_d;
      first_err_cycle_q <= first_err_cycle_d;
      first_err_mask_q  <= first_err_mask_d;
    end
  end

  if (IN_W < 32) begin : g_unused
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_state[31:IN_W];
  end

  assign stim            = lfsr_state[IN_W-1:0];
  assign busy            = busy_w;
  assign done            = (state_q == ST_DONE);
  assign pass            = done && (err_count_q == '0);
  assign err_pulse       = err_pulse_q;
  assign err_count       = err_count_q;
  assign first_err_cycle = first_err_cycle_q;
  assign first_err_mask  = first_err_mask_q;

endmodule

// File: tb/tb_fabric_random_checker.sv
// Scoreboard bench: expected run results are queued when a run is issued and
// popped by monitors when the checker raises done.
module tb_fabric_random_checker;

  typedef struct {
    logic [15:0] err;
    logic [8:0]  fec;
    logic        fem;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;
  logic m_dc = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       exp_q[$];
  logic [1:0] stim_q[$];

  always #5 clk = ~clk;

  // Main instance: default geometry, DUT behaviour selected by mode
  logic [1:0]  m_stim;
  logic [0:0]  m_dut, m_ref, m_dcv, m_fem;
  logic        m_busy, m_done, m_pass, m_pulse;
  logic [15:0] m_err;
  logic [8:0]  m_fec;

  assign m_ref = m_stim[0] & m_stim[1];
  assign m_dut = (mode == 0) ? m_ref : (mode == 1) ? (m_stim[0] | m_stim[1]) : ~m_ref;
  assign m_dcv = m_dc;

  fabric_random_checker #(
    .IN_W(2), .OUT_W(1), .WARMUP(1), .NUM_CYCLES(400), .ERR_W(16), .SEED(32'h1)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(m_stim),
    .dut_out(m_dut), .ref_out(m_ref), .ref_dc(m_dcv),
    .busy(m_busy), .done(m_done), .pass(m_pass), .err_pulse(m_pulse),
    .err_count(m_err), .first_err_cycle(m_fec), .first_err_mask(m_fem)
  );

  // Saturation instance: 3-bit counter, DUT output always inverted
  logic [1:0] s_stim;
  logic [0:0] s_dut, s_ref, s_dcv, s_fem;
  logic       s_busy, s_done, s_pass, s_pulse;
  logic [2:0] s_err;
  logic [4:0] s_fec;

  assign s_ref = s_stim[0] & s_stim[1];
  assign s_dut = ~s_ref;
  assign s_dcv = 1'b0;

  fabric_random_checker #(
    .IN_W(2), .OUT_W(1), .WARMUP(1), .NUM_CYCLES(20), .ERR_W(3), .SEED(32'h1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(s_stim),
    .dut_out(s_dut), .ref_out(s_ref), .ref_dc(s_dcv),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_pulse(s_pulse),
    .err_count(s_err), .first_err_cycle(s_fec), .first_err_mask(s_fem)
  );

  // Zero-seed instance: must behave exactly like SEED=1
  logic [1:0]  z_stim;
  logic [0:0]  z_io, z_dcv, z_fem;
  logic        z_busy, z_done, z_pass, z_pulse;
  logic [15:0] z_err;
  logic [8:0]  z_fec;

  assign z_io  = z_stim[0] & z_stim[1];
  assign z_dcv = 1'b0;

  fabric_random_checker #(
    .IN_W(2), .OUT_W(1), .WARMUP(1), .NUM_CYCLES(400), .ERR_W(16), .SEED(32'h0)
  ) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(z_stim),
    .dut_out(z_io), .ref_out(z_io), .ref_dc(z_dcv),
    .busy(z_busy), .done(z_done), .pass(z_pass), .err_pulse(z_pulse),
    .err_count(z_err), .first_err_cycle(z_fec), .first_err_mask(z_fem)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  // Expected result of one 401-cycle run of the main instance
  function automatic exp_t model(input int md, input logic dc);
    exp_t        e;
    logic [31:0] s;
    logic        a, b, d;
    int          cnt;
    s = 32'd1;
    cnt = 0;
    e.err = '0; e.fec = '0; e.fem = 1'b0; e.pass = 1'b0;
    for (int i = 0; i < 401; i++) begin
      a = s[0];
      b = s[1];
      d = (md == 0) ? (a & b) : (md == 1) ? (a | b) : ~(a & b);
      if (i >= 1 && !dc && (d != (a & b))) begin
        if (cnt == 0) begin
          e.fec = 9'(i);
          e.fem = 1'b1;
        end
        cnt++;
      end
      s = step(s);
    end
    e.err  = 16'(cnt);
    e.pass = (cnt == 0);
    return e;
  endfunction

  // Expected stim for the first 50 busy cycles: hand values, then the model
  task automatic push_stim();
    logic [1:0]  hand [6];
    logic [31:0] s;
    hand = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2};
    s = 32'd1;
    for (int i = 0; i < 50; i++) begin
      stim_q.push_back((i < 6) ? hand[i] : s[1:0]);
      s = step(s);
    end
  endtask

  // Monitor: main instance result check on done rising
  int   m_busy_cnt = 0;
  int   m_pulse_cnt = 0;
  logic m_done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_busy_cnt  = 0;
      m_pulse_cnt = 0;
      m_done_prev = 1'b0;
    end else begin
      if (m_busy) m_busy_cnt++;
      if (m_pulse) m_pulse_cnt++;
      if (m_done && !m_done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(m_done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_count", 64'(m_err), 64'(e.err));
          check("first_err_cycle", 64'(m_fec), 64'(e.fec));
          check("first_err_mask", 64'(m_fem), 64'(e.fem));
          check("pass", 64'(m_pass), 64'(e.pass));
          check("busy_len", 64'(m_busy_cnt), 64'd401);
          check("err_pulses", 64'(m_pulse_cnt), 64'(e.err));
        end
        m_busy_cnt  = 0;
        m_pulse_cnt = 0;
      end
      m_done_prev = m_done;
    end
  end

  // Monitor: stim sequence of main and zero-seed instances
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && m_busy && stim_q.size() > 0) begin
      e = stim_q.pop_front();
      check("stim_seq", 64'(m_stim), 64'(e));
      check("stim_seed0", 64'(z_stim), 64'(e));
    end
  end

  // Monitor: saturation instance result on done rising
  int   s_pulse_cnt = 0;
  logic s_done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_pulse_cnt = 0;
      s_done_prev = 1'b0;
    end else begin
      if (s_pulse) s_pulse_cnt++;
      if (s_done && !s_done_prev) begin
        check("sat_err_count", 64'(s_err), 64'd7);
        check("sat_pass", 64'(s_pass), 64'd0);
        check("sat_pulses", 64'(s_pulse_cnt), 64'd20);
        check("sat_first_cycle", 64'(s_fec), 64'd1);
        check("sat_first_mask", 64'(s_fem), 64'd1);
        s_pulse_cnt = 0;
      end
      s_done_prev = s_done;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_stim"}, 64'(m_stim), 64'd1);
    check({tag, "_busy"}, 64'(m_busy), 64'd0);
    check({tag, "_done"}, 64'(m_done), 64'd0);
    check({tag, "_pass"}, 64'(m_pass), 64'd0);
    check({tag, "_pulse"}, 64'(m_pulse), 64'd0);
    check({tag, "_err"}, 64'(m_err), 64'd0);
    check({tag, "_fec"}, 64'(m_fec), 64'd0);
    check({tag, "_fem"}, 64'(m_fem), 64'd0);
    check({tag, "_sat_err"}, 64'(s_err), 64'd0);
    check({tag, "_sat_done"}, 64'(s_done), 64'd0);
    check({tag, "_seed0_stim"}, 64'(z_stim), 64'd1);
  endtask

  // Issue one run; extra start pulses land while every instance is busy
  task automatic run(input int md, input logic dc, input logic push, input logic extra);
    mode = md;
    m_dc = dc;
    if (push) exp_q.push_back(model(md, dc));
    push_stim();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_busy", 64'(m_busy), 64'd1);
    check("start_done_low", 64'(m_done), 64'd0);
    if (extra) begin
      for (int k = 0; k < 3; k++) begin
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && !m_done; i++) @(negedge clk);
    if (!m_done) check("done_timeout", 64'(m_done), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run(0, 1'b0, 1'b1, 1'b0);  // DUT == REF
    wait_done();
    run(1, 1'b0, 1'b1, 1'b0);  // DUT = a|b
    wait_done();
    run(1, 1'b1, 1'b1, 1'b0);  // same mismatch, fully masked
    wait_done();

    // Abort at RUN cycle 100 (the run task returns at index 0)
    run(1, 1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(1, 1'b0, 1'b1, 1'b1);  // fresh run with ignored start pulses
    wait_done();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
